// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   dmem_req_t   : request latch {we, addr, wdata}, sized by the DMEM_*_W
//                  defaults below (the responder's DATA_W/ADDR_W must not
//                  exceed them)
//   DMEM_WORD_BYTES : bytes per data word; log2 of it is the ignored
//                     address offset width
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int unsigned DMEM_WORD_BYTES = 8;
    localparam int unsigned DMEM_DATA_W     = 64;
    localparam int unsigned DMEM_ADDR_W     = 32;
    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int unsigned DMEM_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port DEPTH x DATA_W storage: synchronous write, registered read,
// plus a side-effect-free combinational debug read.
//   clk, reset  : clock, synchronous active-high reset (read register only;
//                 the storage itself is never cleared)
//   we, re      : write / read strobes, both addressed by addr
//   addr        : word index
//   wdata       : write data
//   rdata       : registered read data; 0 on any cycle without a read
//   dbg_addr    : debug word index
//   dbg_rdata   : combinational read at dbg_addr
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Returning zero when no read is requested keeps store responses and
    // idle cycles at 0 without extra muxing in the responder.
    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign dbg_rdata = mem_q[dbg_addr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder at the far end of the LSU memory port. Accepts one
// request at a time and answers with a one-cycle mem_ready pulse LATENCY
// cycles after acceptance. Squashed loads are cancelled by flush; stores
// always complete.
//   clk, reset       : clock, synchronous active-high reset
//   mem_req          : request valid (held by initiator until mem_ready)
//   mem_we           : 1 = store, 0 = load (sampled at acceptance)
//   mem_addr         : byte address (sampled at acceptance, low 3 bits ignored)
//   mem_wdata        : store data (sampled at acceptance)
//   flush            : pipeline flush; cancels an in-flight load
//   mem_ready        : one-cycle response pulse
//   mem_rdata        : load data, valid while mem_ready
//   mem_err          : only with DMEM_BOUNDS_CHECK_EN; misaligned or
//                      out-of-range access, asserted with mem_ready
//   busy             : request in flight
//   dbg_addr         : backdoor word index
//   dbg_rdata        : combinational backdoor read
// Build option: define DMEM_BOUNDS_CHECK_EN to add mem_err and suppress
// erroneous accesses; otherwise addresses wrap modulo DEPTH.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W  = DMEM_DATA_W,
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic                     flush,
    output logic                     mem_ready,
    output logic [DATA_W-1:0]        mem_rdata,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic                     mem_err,
`endif
    output logic                     busy,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_rdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = $clog2(DMEM_WORD_BYTES);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic                  err_q, err_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  mem_err_q, mem_err_d;
    logic                  busy_q, busy_d;

    logic                  acc_err;
    logic                  arr_we;
    logic                  arr_re;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_W-1:0]     arr_rdata;

    assign req_idx = IDX_W'(req_q.addr[ADDR_W-1:OFF_W] % DEPTH);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign acc_err = (mem_addr[OFF_W-1:0] != '0) ||
                     (ADDR_W'(mem_addr[ADDR_W-1:OFF_W]) >= ADDR_W'(DEPTH));
    assign mem_err = mem_err_q;
    logic unused_addr_off;
    assign unused_addr_off = ^req_q.addr[OFF_W-1:0];
`else
    assign acc_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{req_q.addr[OFF_W-1:0], mem_err_q};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        err_d       = err_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        arr_we      = 1'b0;
        arr_re      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req && !flush) begin
                    req_d.we    = mem_we;
                    req_d.addr  = DMEM_ADDR_W'(mem_addr);
                    req_d.wdata = DMEM_DATA_W'(mem_wdata);
                    err_d       = acc_err;
                    cnt_d       = DMEM_CNT_W'(LATENCY - 1);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // Flush outranks the final countdown step, so a load can be
                // cancelled right up to the edge that would enter RESP.
                if (flush && !req_q.we) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_err_d   = err_q;
                    arr_we      = req_q.we && !err_q;
                    arr_re      = !req_q.we && !err_q;
                end else begin
                    cnt_d = cnt_q - DMEM_CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            err_q       <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            err_q       <= err_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            busy_q      <= busy_d;
        end
    end

    // Strobes are gated by reset so an aborted store never reaches the array.
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .we        (arr_we && !reset),
        .re        (arr_re && !reset),
        .addr      (req_idx),
        .wdata     (DATA_W'(req_q.wdata)),
        .rdata     (arr_rdata),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    assign mem_ready = mem_ready_q;
    assign mem_rdata = arr_rdata;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic        flush = 1'b0;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_err_w;
    logic        busy;
    logic [9:0]  dbg_addr = '0;
    logic [63:0] dbg_rdata;

    int vectors = 0;
    int errors  = 0;

    dmem_responder #(
        .DATA_W  (64),
        .ADDR_W  (32),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .flush     (flush),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
`ifdef DMEM_BOUNDS_CHECK_EN
        .mem_err   (mem_err_w),
`endif
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );
`ifndef DMEM_BOUNDS_CHECK_EN
    assign mem_err_w = 1'b0;
`endif

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (time-based) ----------------
    // A request accepted at edge A answers after edge A+LATENCY and the
    // responder can accept again from edge A+LATENCY+2. A flushed load
    // frees it from the following edge.
    logic [63:0] mm [DEPTH];
    bit          known [DEPTH];
    int          n = -1;
    int          next_free = 0;
    bit          pend = 1'b0;
    int          t_resp;
    bit          t_we, t_err;
    int unsigned t_idx;
    logic [63:0] t_wd;
    bit          ready_e = 1'b0, busy_e = 1'b0, err_e = 1'b0;
    bit          rdata_ok = 1'b0, rst_seen = 1'b0;
    logic [63:0] rdata_e = '0;

    task automatic model_step();
        int unsigned a;
        n++;
        rst_seen = reset;
        ready_e  = 1'b0;
        err_e    = 1'b0;
        rdata_ok = 1'b0;
        rdata_e  = '0;
        if (reset) begin
            pend      = 1'b0;
            next_free = n + 1;
        end else if (pend && flush && !t_we) begin
            pend      = 1'b0;
            next_free = n + 1;
        end else if (pend && n == t_resp) begin
            pend    = 1'b0;
            ready_e = 1'b1;
            err_e   = t_err;
            if (t_we) begin
                rdata_ok = 1'b1;
                if (!t_err) begin
                    mm[t_idx]    = t_wd;
                    known[t_idx] = 1'b1;
                end
            end else if (t_err) begin
                rdata_ok = 1'b1;
            end else begin
                rdata_e  = mm[t_idx];
                rdata_ok = known[t_idx];
            end
        end else if (!pend && n >= next_free && mem_req && !flush) begin
            a         = mem_addr;
            pend      = 1'b1;
            t_we      = mem_we;
            t_wd      = mem_wdata;
            t_idx     = (a >> 3) % DEPTH;
            t_err     = BOUNDS && (((a & 7) != 0) || ((a >> 3) >= DEPTH));
            t_resp    = n + LATENCY;
            next_free = n + LATENCY + 2;
        end
        busy_e = (n < next_free - 1);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (n >= 0) begin
            chk("mem_ready", 64'(mem_ready), 64'(ready_e));
            chk("busy", 64'(busy), 64'(busy_e));
            if (ready_e && rdata_ok) chk("mem_rdata", mem_rdata, rdata_e);
            if (rst_seen) chk("rst_rdata", mem_rdata, 64'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
            chk("mem_err", 64'(mem_err_w), 64'(err_e));
`endif
            if (known[dbg_addr]) chk("dbg_rdata", dbg_rdata, mm[dbg_addr]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        tick();
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (mem_ready) begin
                got = 1'b1;
                rd  = mem_rdata;
                er  = mem_err_w;
            end
        end
        mem_req = 1'b0;
        chk("xact_done", 64'(got), 64'd1);
    endtask

    initial begin
        logic [63:0] rd, rd1, rd2;
        logic        er;
        int          lat, pulses, first, second, found;
        int unsigned idx, low;

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata_lit", mem_rdata, 64'd0);

        // store then load 0x40
        xact(1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D, rd, er, lat);
        chk("st_lat", 64'(lat), 64'(LATENCY + 1));
        chk("st_rdata_zero", rd, 64'd0);
        xact(1'b0, 32'h40, 64'd0, rd, er, lat);
        chk("ld_lat", 64'(lat), 64'(LATENCY + 1));
        chk("ld_rdata", rd, 64'hDEADBEEF_CAFEF00D);
        dbg_addr = 10'd8; #1;
        chk("dbg8", dbg_rdata, 64'hDEADBEEF_CAFEF00D);

        // held mem_req across two loads
        xact(1'b1, 32'h0, 64'd1, rd, er, lat);
        xact(1'b1, 32'h8, 64'd2, rd, er, lat);
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0;
        pulses = 0; first = -1; second = -1; rd1 = '0; rd2 = '0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (mem_ready) begin
                pulses++;
                if (pulses == 1) begin
                    first = c; rd1 = mem_rdata; mem_addr = 32'h8;
                end else if (pulses == 2) begin
                    second = c; rd2 = mem_rdata; mem_req = 1'b0;
                end
            end
        end
        mem_req = 1'b0;
        chk("held_pulses", 64'(pulses), 64'd2);
        chk("held_first", 64'(first), 64'(LATENCY + 1));
        chk("held_gap", 64'(second - first), 64'(LATENCY + 2));
        chk("held_rd1", rd1, 64'd1);
        chk("held_rd2", rd2, 64'd2);

        // flush a load
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
        tick();
        chk("fl_busy_wait", 64'(busy), 64'd1);
        mem_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy_idle", 64'(busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_ready) pulses++;
        end
        chk("fl_no_ready", 64'(pulses), 64'd0);
        xact(1'b0, 32'h10, 64'd0, rd, er, lat);
        chk("fl_next_lat", 64'(lat), 64'(LATENCY + 1));

        // flush a store: no effect
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h18; mem_wdata = 64'h55;
        tick();
        mem_req = 1'b0; flush = 1'b1;
        tick();
        found = -1;
        for (int c = 1; c <= 10 && found < 0; c++) begin
            tick();
            flush = 1'b0;
            if (mem_ready) found = c;
        end
        chk("fs_ready_cycle", 64'(found), 64'd1);
        dbg_addr = 10'd3; #1;
        chk("fs_dbg3", dbg_rdata, 64'h55);

        // reset in the middle of a store
        xact(1'b1, 32'h20, 64'h11, rd, er, lat);
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 64'hAA;
        tick();
        mem_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_ready", 64'(mem_ready), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        dbg_addr = 10'd4; #1;
        chk("rs_dbg4", dbg_rdata, 64'h11);
        xact(1'b0, 32'h20, 64'd0, rd, er, lat);
        chk("rs_ld", rd, 64'h11);
        chk("rs_ld_lat", 64'(lat), 64'(LATENCY + 1));

`ifdef DMEM_BOUNDS_CHECK_EN
        xact(1'b1, 32'h2004, 64'h99, rd, er, lat);
        chk("bc_st_err", 64'(er), 64'd1);
        dbg_addr = 10'd0; #1;
        chk("bc_no_write", dbg_rdata, 64'd1);
        xact(1'b0, 32'h2000, 64'd0, rd, er, lat);
        chk("bc_ld_err", 64'(er), 64'd1);
        chk("bc_ld_rdata", rd, 64'd0);
`else
        xact(1'b1, 32'h2000, 64'h77, rd, er, lat);
        dbg_addr = 10'd0; #1;
        chk("alias_dbg0", dbg_rdata, 64'h77);
        xact(1'b0, 32'h0, 64'd0, rd, er, lat);
        chk("alias_ld", rd, 64'h77);
`endif

        // randomized traffic, checked by the per-cycle compare
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset   = ($urandom_range(0, 255) == 0);
            mem_req = ($urandom_range(0, 1) == 1);
            mem_we  = ($urandom_range(0, 1) == 1);
            flush   = ($urandom_range(0, 7) == 0);
            idx     = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) idx += DEPTH;
            low     = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
            mem_addr = (idx << 3) | low;
            if ($urandom_range(0, 15) == 0) mem_addr = $urandom;
            mem_wdata = {$urandom, $urandom};
            dbg_addr  = 10'($urandom_range(0, 15));
        end
        tick();
        reset = 1'b0; mem_req = 1'b0; flush = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
